mem_target: RTL and testbench
=============================

Name: mem_target

Overview:
- Memory-side responder for the CPU's data/instruction bus: the far end of the CPU's memory request interface.
- Accepts word, half and byte read/write requests, inserts programmable wait states, then answers with a one-cycle ack.
- Internal storage is a byte-addressed, little-endian register array.
- Used as the memory model behind the CPU in system benches and as the template for slower peripherals.

Parameters:
- ADDR_BITS, 8: byte-address width of the storage; 2^ADDR_BITS bytes, organised as 2^(ADDR_BITS-2) 32-bit words.
- WAIT_CYCLES, 2: extra wait states per access; legal range 0..15.

Ports:
- clk  in  1  system clock; rising edge active.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- size  in  2  00 word, 01 half, 10 byte; 11 reserved and treated as word.
- addr  in  32  byte address.
- wdata  in  32  write data, right-aligned: half in [15:0], byte in [7:0].
- busy  out  1  high from the cycle after req is accepted until the return to IDLE.
- ack  out  1  one-cycle pulse marking completion of an access.
- rdata  out  32  read result, zero-extended; valid while ack=1 for reads and held until the next read completes.
- err  out  1  bus error flag, valid only while ack=1.

Behaviour:
- Reset: while rst=0, state=IDLE and busy=0, ack=0, err=0, rdata=0. All storage bytes clear to 0x00. The wait counter clears to 0. Asserting rst mid-access aborts the access and performs no write.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req=1 at a clk edge, latch addr/we/size/wdata, load cnt=WAIT_CYCLES, go to WAIT.
  - WAIT: if cnt!=0, decrement cnt. If cnt==0, perform the access at that edge and go to RESP.
  - RESP: ack=1 for exactly one cycle, then go to IDLE at the next edge.
- Latency: req accepted at edge N gives ack=1 in the cycle starting at edge N+1+WAIT_CYCLES. Back-to-back requests therefore start WAIT_CYCLES+3 edges apart.
- req while busy=1, including the RESP cycle: ignored, not queued. Request inputs may change freely after acceptance.
- Reads (little-endian):
  - word: rdata = bytes [a+3:a].
  - half: rdata = {16'b0, half selected by addr[1]}.
  - byte: rdata = {24'b0, byte selected by addr[1:0]}.
- Writes:
  - Only the addressed byte lanes change.
  - half writes wdata[15:0]; byte writes wdata[7:0].
  - rdata is unchanged by writes.
- Address handling without the error feature:
  - addr bits above ADDR_BITS-1 are ignored, so addresses wrap modulo 2^ADDR_BITS.
  - Misaligned low bits are forced to alignment: word ignores addr[1:0], half ignores addr[0].
- busy=1 in WAIT and RESP; busy=0 only in IDLE.

Optional Feature:
- Macro: MEM_TARGET_BUSERR_EN.
- Defined:
  - Accesses are checked when the request is latched.
  - Error conditions: word with addr[1:0]!=0, half with addr[0]!=0, or any addr >= 2^ADDR_BITS.
  - A faulting access still runs the full wait sequence. It then acks with err=1, performs no write and leaves rdata unchanged.
  - Clean accesses ack with err=0.
- Not defined: err is tied to 0 and the wrap/alignment rules above apply.

Test Plan:
- Reset: drive rst=0 mid-WAIT, then release -> busy=0, ack=0, rdata=0; a word read of 0x00 returns 0x00000000 and no write occurred.
- Latency, WAIT_CYCLES=2: write word 0xDEADBEEF to 0x10 at edge N -> ack high only in the cycle after edge N+3. A word read of 0x10 -> rdata=0xDEADBEEF.
- Sub-word, after the previous write:
  - half read of 0x12 -> 0x0000DEAD; byte read of 0x11 -> 0x000000BE.
  - byte write 0x55 to 0x13, then word read of 0x10 -> 0x55ADBEEF.
- Busy handling: hold req=1 continuously with alternating addresses -> exactly one ack per WAIT_CYCLES+3 edges. A req asserted during the RESP cycle is dropped, with no extra ack.
- Wrap, ADDR_BITS=8, macro undefined: word write 0x12345678 to 0x104 -> word read of 0x04 returns 0x12345678 and err stays 0.
- Error path, macro defined: word read of 0x02 -> ack with err=1 and rdata unchanged. Word write to 0x100 -> err=1 and all storage unchanged.

Source files
------------

// File: rtl/mem_target.sv
// mem_target: memory-side responder for the CPU request bus.
// Accepts word/half/byte reads and writes, inserts WAIT_CYCLES wait states,
// then pulses ack for one cycle. Storage is a byte-addressed, little-endian
// array organised as 32-bit words with per-lane write enables.
// Optional build macro MEM_TARGET_BUSERR_EN: flags misaligned or out-of-range
// accesses with err=1 instead of wrapping/aligning them.
module mem_target #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int WORDS = 2 ** (ADDR_BITS - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_mem [WORDS];

    logic [ADDR_BITS-3:0] w_idx;
    logic                 w_is_half;
    logic                 w_is_byte;
    logic [1:0]           w_lane;
    logic [3:0]           w_be;
    logic [31:0]          w_mask;
    logic [31:0]          w_wd_sh;
    logic [31:0]          w_word;
    logic [31:0]          w_rd_sh;
    logic [31:0]          w_rd;
    logic                 w_access;
    logic                 w_do_write;
    logic                 w_fault_in;

`ifdef MEM_TARGET_BUSERR_EN
    // Fault if misaligned for its size or if any address bit lies above the storage.
    always_comb begin
        w_fault_in = |addr[31:ADDR_BITS];
        if (size == 2'b01)
            w_fault_in = w_fault_in | addr[0];
        else if (size != 2'b10)
            w_fault_in = w_fault_in | (addr[1:0] != 2'b00);
    end
`else
    // Without error checking, upper address bits are don't-care (addresses wrap).
    logic w_unused_hi;
    assign w_unused_hi = ^addr[31:ADDR_BITS];
    assign w_fault_in  = 1'b0;
`endif

    // Decode the latched request into a word index, lane, byte enables and read data.
    always_comb begin
        w_idx     = r_addr[ADDR_BITS-1:2];
        w_is_half = (r_size == 2'b01);
        w_is_byte = (r_size == 2'b10);
        if (w_is_byte) begin
            w_lane = r_addr[1:0];
            w_be   = 4'b0001 << r_addr[1:0];
        end else if (w_is_half) begin
            w_lane = {r_addr[1], 1'b0};
            w_be   = 4'b0011 << {r_addr[1], 1'b0};
        end else begin
            w_lane = 2'b00;
            w_be   = 4'b1111;
        end
        w_wd_sh = r_wdata << {w_lane, 3'b000};
        w_word  = r_mem[w_idx];
        w_rd_sh = w_word >> {w_lane, 3'b000};
        if (w_is_byte)
            w_rd = {24'b0, w_rd_sh[7:0]};
        else if (w_is_half)
            w_rd = {16'b0, w_rd_sh[15:0]};
        else
            w_rd = w_word;
    end

    // Expand byte enables into a bit mask, one lane at a time.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign w_mask[gi*8 +: 8] = {8{w_be[gi]}};
        end
    endgenerate

    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_do_write = w_access && r_we && !r_fault;

    // Request FSM: latch in IDLE, count down wait states, one-cycle response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_fault <= 1'b0;
            busy    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ack <= 1'b0;
                    err <= 1'b0;
                    if (req) begin
                        r_we    <= we;
                        r_size  <= size;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_fault <= w_fault_in;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we && !r_fault)
                            rdata <= w_rd;
                        err     <= r_fault;
                        ack     <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ack     <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage: clears on reset; merges write data into the enabled byte lanes only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORDS; i++)
                r_mem[i] <= 32'd0;
        end else if (w_do_write) begin
            r_mem[w_idx] <= (w_word & ~w_mask) | (w_wd_sh & w_mask);
        end
    end

endmodule

// File: tb/tb_mem_target.sv
// Directed testbench for mem_target (ADDR_BITS=8, WAIT_CYCLES=2).
module tb_mem_target;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    mem_target #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .ack   (ack),
        .rdata (rdata),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected summary before limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // One access: drive req for a single edge, wait (bounded) for ack, check the pulse ends.
    task automatic access(input string tag, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req = 1'b1; we = w; size = s; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (!ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata;
        e  = err;
        chk({tag, "_lat"}, lat, 32'd3);
        $display("access %s we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d",
                 tag, w, s, a, d, rd, e, lat);
        @(negedge clk);
        chk({tag, "_ackpulse"}, {31'b0, ack}, 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          n_ack;
    int          last;

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_ack",   {31'b0, ack},  32'd0);
        chk("rst_err",   {31'b0, err},  32'd0);
        chk("rst_rdata", rdata,         32'd0);
        rst = 1'b1;

        // Reset in the middle of a write aborts it.
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h00; wdata = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0;
        chk("abort_busy_wait", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ack",  {31'b0, ack},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("abort_rdata", rdata, 32'd0);
        access("rd00_after_abort", 1'b0, 2'b00, 32'h00, 32'h0, rd, e, lat);
        chk("rd00_after_abort", rd, 32'h00000000);

        // Word write then read, sub-word reads and a byte write.
        access("wr10", 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rd, e, lat);
        chk("wr10_err", {31'b0, e}, 32'd0);
        chk("wr10_rdata_held", rd, 32'h00000000);
        access("rd10", 1'b0, 2'b00, 32'h10, 32'h0, rd, e, lat);
        chk("rd10", rd, 32'hDEADBEEF);
        access("rdh12", 1'b0, 2'b01, 32'h12, 32'h0, rd, e, lat);
        chk("rdh12", rd, 32'h0000DEAD);
        access("rdb11", 1'b0, 2'b10, 32'h11, 32'h0, rd, e, lat);
        chk("rdb11", rd, 32'h000000BE);
        access("wrb13", 1'b1, 2'b10, 32'h13, 32'hFFFFFF55, rd, e, lat);
        chk("wrb13_rdata_held", rd, 32'h000000BE);
        access("rd10b", 1'b0, 2'b00, 32'h10, 32'h0, rd, e, lat);
        chk("rd10b", rd, 32'h55ADBEEF);

`ifdef MEM_TARGET_BUSERR_EN
        access("rd02_mis", 1'b0, 2'b00, 32'h02, 32'h0, rd, e, lat);
        chk("rd02_err", {31'b0, e}, 32'd1);
        chk("rd02_rdata_held", rd, 32'h55ADBEEF);
        access("rdh13_mis", 1'b0, 2'b01, 32'h13, 32'h0, rd, e, lat);
        chk("rdh13_err", {31'b0, e}, 32'd1);
        access("wr100_oor", 1'b1, 2'b00, 32'h100, 32'hFFFFFFFF, rd, e, lat);
        chk("wr100_err", {31'b0, e}, 32'd1);
        access("rd00_clean", 1'b0, 2'b00, 32'h00, 32'h0, rd, e, lat);
        chk("rd00_clean", rd, 32'h00000000);
        chk("rd00_clean_err", {31'b0, e}, 32'd0);
        access("rd10_clean", 1'b0, 2'b00, 32'h10, 32'h0, rd, e, lat);
        chk("rd10_clean", rd, 32'h55ADBEEF);
`else
        access("rdh13_align", 1'b0, 2'b01, 32'h13, 32'h0, rd, e, lat);
        chk("rdh13_align", rd, 32'h000055AD);
        access("rd11_align", 1'b0, 2'b00, 32'h11, 32'h0, rd, e, lat);
        chk("rd11_align", rd, 32'h55ADBEEF);
        access("wrh11", 1'b1, 2'b01, 32'h11, 32'hAAAA1234, rd, e, lat);
        access("rd10_rsv", 1'b0, 2'b11, 32'h10, 32'h0, rd, e, lat);
        chk("rd10_rsv", rd, 32'h55AD1234);
        access("wr104_wrap", 1'b1, 2'b00, 32'h104, 32'h12345678, rd, e, lat);
        chk("wr104_err", {31'b0, e}, 32'd0);
        access("rd04_wrap", 1'b0, 2'b00, 32'h04, 32'h0, rd, e, lat);
        chk("rd04_wrap", rd, 32'h12345678);
        chk("rd04_err", {31'b0, e}, 32'd0);
        access("rdb107_wrap", 1'b0, 2'b10, 32'h107, 32'h0, rd, e, lat);
        chk("rdb107_wrap", rd, 32'h00000012);
`endif

        // Continuous req: one ack every WAIT_CYCLES+3 = 5 edges.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h10;
        n_ack = 0;
        last  = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            addr = (i % 2 == 1) ? 32'h04 : 32'h10;
            if (ack) begin
                n_ack++;
                if (last >= 0) chk("ack_gap", i - last, 32'd5);
                last = i;
            end
        end
        req = 1'b0;
        chk("ack_count", n_ack, 32'd4);
        $display("busy_hold: acks=%0d over 20 edges", n_ack);

        // A req raised only during the RESP cycle is dropped.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b00; addr = 32'h10;
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (!ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("resp_drop_lat", lat, 32'd3);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("resp_drop_busy", {31'b0, busy}, 32'd0);
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        chk("resp_drop_acks", n_ack, 32'd0);
        $display("resp_drop: extra acks=%0d", n_ack);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
